// File: rtl/sys_cntr_pkg.sv
// rtl/sys_cntr_pkg.sv - shared system-controller states and frame-type constants
package sys_cntr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } tx_state_e;

    // The frame type doubles as the index of the frame's last byte.
    localparam logic FRM_RD  = 1'b0;
    localparam logic FRM_ALU = 1'b1;

    function automatic logic more_bytes(input logic idx, input logic frm_type);
        return idx != frm_type;
    endfunction

endpackage

// File: rtl/sys_cntr_tx_if.sv
// rtl/sys_cntr_tx_if.sv - source strobes, UART handshake and status of the transmit controller
interface sys_cntr_tx_if #(
    parameter int width = 8
);
    logic [width-1:0]   RdData;
    logic               RdData_Valid;
    logic [2*width-1:0] ALU_OUT;
    logic               OUT_Valid;
    logic               Busy;
    logic [width-1:0]   TX_P_Data;
    logic               TX_D_VLD;
    logic               Ctrl_Busy;
    logic               Drop;

    modport master (
        output RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        input  TX_P_Data, TX_D_VLD, Ctrl_Busy, Drop
    );

    modport slave (
        input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, Busy,
        output TX_P_Data, TX_D_VLD, Ctrl_Busy, Drop
    );
endinterface

// File: rtl/sys_cntr_tx_pend.sv
// rtl/sys_cntr_tx_pend.sv - one-frame holding buffer for the transmit controller
module sys_cntr_tx_pend
    import sys_cntr_pkg::*;
#(
    parameter int width = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               push,
    input  logic [2*width-1:0] push_data,
    input  logic               push_len,
    input  logic               pop,
    output logic               pend_valid,
    output logic [2*width-1:0] pend_data,
    output logic               pend_len
);

    // The caller only pushes when the slot is empty or is being popped this cycle.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend_valid <= 1'b0;
            pend_data  <= '0;
            pend_len   <= FRM_RD;
        end else if (push) begin
            pend_valid <= 1'b1;
            pend_data  <= push_data;
            pend_len   <= push_len;
        end else if (pop) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sys_cntr_tx.sv
// rtl/sys_cntr_tx.sv - frames register/ALU results into bytes for a UART; SYS_CNTR_TX_PEND_EN adds a pending frame
module sys_cntr_tx
    import sys_cntr_pkg::*;
#(
    parameter int width = 8
) (
    input  logic        CLK,
    input  logic        Reset,
    sys_cntr_tx_if.slave bus
);

    tx_state_e        state_q, state_d;
    logic [width-1:0] hi_q, hi_d;
    logic             len_q, len_d;
    logic             idx_q, idx_d;
    logic [width-1:0] tx_data_q, tx_data_d;
    logic             tx_vld_q, tx_vld_d;
    logic             drop_q, drop_d;
    logic             ctrl_busy_q;
    logic             ext_rd, ext_alu;

    // Strobes that cannot start a frame right now: anything outside IDLE,
    // and the ALU strobe when it collides with a register read in IDLE.
    assign ext_rd  = bus.RdData_Valid && (state_q != IDLE);
    assign ext_alu = bus.OUT_Valid && ((state_q != IDLE) || bus.RdData_Valid);

`ifdef SYS_CNTR_TX_PEND_EN
    logic               push, pop, can_push;
    logic [2*width-1:0] push_data, pend_data, rd_frame;
    logic               push_len, pend_valid, pend_len;

    assign rd_frame = {{width{1'b0}}, bus.RdData};

    sys_cntr_tx_pend #(.width(width)) u_pend (
        .CLK        (CLK),
        .Reset      (Reset),
        .push       (push),
        .push_data  (push_data),
        .push_len   (push_len),
        .pop        (pop),
        .pend_valid (pend_valid),
        .pend_data  (pend_data),
        .pend_len   (pend_len)
    );
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        drop_d    = 1'b0;
`ifdef SYS_CNTR_TX_PEND_EN
        pop       = 1'b0;
        push      = 1'b0;
        push_data = rd_frame;
        push_len  = FRM_RD;
        can_push  = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (bus.RdData_Valid) begin
                    hi_d      = '0;
                    len_d     = FRM_RD;
                    idx_d     = 1'b0;
                    tx_data_d = bus.RdData;
                    tx_vld_d  = 1'b1;
                    state_d   = SEND;
                end else if (bus.OUT_Valid) begin
                    hi_d      = bus.ALU_OUT[2*width-1:width];
                    len_d     = FRM_ALU;
                    idx_d     = 1'b0;
                    tx_data_d = bus.ALU_OUT[width-1:0];
                    tx_vld_d  = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (!bus.Busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.Busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.Busy) begin
                    if (more_bytes(idx_q, len_q)) begin
                        idx_d     = 1'b1;
                        tx_data_d = hi_q;
                        tx_vld_d  = 1'b1;
                        state_d   = SEND;
                    end
`ifdef SYS_CNTR_TX_PEND_EN
                    else if (pend_valid) begin
                        pop       = 1'b1;
                        hi_d      = pend_data[2*width-1:width];
                        len_d     = pend_len;
                        idx_d     = 1'b0;
                        tx_data_d = pend_data[width-1:0];
                        tx_vld_d  = 1'b1;
                        state_d   = SEND;
                    end
`endif
                    else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                tx_vld_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

`ifdef SYS_CNTR_TX_PEND_EN
        // The slot frees up in the same cycle it hands its frame over.
        can_push = !pend_valid || pop;
        if (ext_rd) begin
            if (can_push) begin
                push = 1'b1;
            end else begin
                drop_d = 1'b1;
            end
        end
        if (ext_alu) begin
            if (ext_rd || !can_push) begin
                drop_d = 1'b1;
            end else begin
                push      = 1'b1;
                push_data = bus.ALU_OUT;
                push_len  = FRM_ALU;
            end
        end
`else
        drop_d = ext_rd || ext_alu;
`endif
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            len_q       <= FRM_RD;
            idx_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            drop_q      <= 1'b0;
            ctrl_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            drop_q      <= drop_d;
            ctrl_busy_q <= (state_d != IDLE);
        end
    end

    assign bus.TX_P_Data = tx_data_q;
    assign bus.TX_D_VLD  = tx_vld_q;
    assign bus.Ctrl_Busy = ctrl_busy_q;
    assign bus.Drop      = drop_q;

endmodule

// File: doc/sys_cntr_tx.md
SYS_CNTR_TX -- requirements
Module: sys_cntr_tx

Interface
REQ-001 Parameter width, default 8, SHALL set the byte width of register-file read data and UART transmit data.
REQ-002 Port CLK  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 Port Reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 Port RdData  input  width  SHALL be register-file read data, sampled when RdData_Valid=1.
REQ-005 Port RdData_Valid  input  1  SHALL be a one-cycle strobe marking RdData valid.
REQ-006 Port ALU_OUT  input  2*width  SHALL be the ALU result, sampled when OUT_Valid=1.
REQ-007 Port OUT_Valid  input  1  SHALL be a one-cycle strobe marking ALU_OUT valid.
REQ-008 Port Busy  input  1  SHALL be the UART transmitter busy flag; Busy=0 means it can accept a byte.
REQ-009 Port TX_P_Data  output  width  SHALL carry the byte offered to the UART transmitter.
REQ-010 Port TX_D_VLD  output  1  SHALL mark TX_P_Data valid.
REQ-011 Port Ctrl_Busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-012 Port Drop  output  1  SHALL pulse for one cycle when an incoming frame is discarded.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 A frame SHALL be one byte (RdData) or two bytes (ALU_OUT: bits [width-1:0] first, then [2*width-1:width]).
REQ-015 States SHALL be IDLE, SEND, WAIT_HI and WAIT_LO, with a 1-bit byte index and 1-bit frame length.
REQ-016 IDLE: a strobe sampled at edge N SHALL capture its data and enter SEND, with TX_D_VLD=1 and the first byte valid from N+1 onward.
REQ-017 SEND: TX_D_VLD=1 with TX_P_Data stable; a byte transfers on a cycle where TX_D_VLD=1 and Busy=0; the next state is WAIT_HI and TX_D_VLD=0 from the following cycle.
REQ-018 WAIT_HI: wait for Busy=1, then go to WAIT_LO; prevents double acceptance before Busy rises.
REQ-019 WAIT_LO: on Busy=0, go to SEND with the next byte if bytes remain; otherwise go to IDLE (or to SEND if a pending frame exists, per REQ-024).
REQ-020 If RdData_Valid and OUT_Valid are both 1 in IDLE, RdData SHALL win and the ALU frame SHALL go to REQ-024/REQ-025 handling.
REQ-021 A strobe arriving in any non-IDLE state SHALL be handled per REQ-024/REQ-025; the frame in flight is never disturbed.
REQ-022 TX_D_VLD SHALL be 0 in IDLE, WAIT_HI and WAIT_LO.

Reset
REQ-023 On Reset=1 at a clock edge, the state SHALL go to IDLE and TX_P_Data, TX_D_VLD, Ctrl_Busy, Drop, the capture registers, index and pending buffer SHALL go to 0; a partially sent frame is abandoned and no further bytes of it are sent.

Configuration
REQ-024 With SYS_CNTR_TX_PEND_EN defined, a one-frame pending buffer SHALL hold one frame that arrives while not IDLE (or loses the REQ-020 priority); it is sent immediately after the current frame with no IDLE cycle; a further frame arriving while the buffer is full SHALL be discarded and Drop pulsed.
REQ-025 Without SYS_CNTR_TX_PEND_EN, every frame that arrives while not IDLE (or loses the REQ-020 priority) SHALL be discarded and Drop pulsed, and no buffer logic SHALL be synthesized.

Structure
REQ-026 State encodings and frame-type constants (FRM_RD, FRM_ALU) SHALL live in the shared package sys_cntr_pkg, shared with the receive-side controller.
REQ-027 The pending buffer SHALL be a sub-module sys_cntr_tx_pend, instantiated only under SYS_CNTR_TX_PEND_EN.

Verification
REQ-028 RdData=0x5A strobe, Busy model idle -> TX_P_Data=0x5A with TX_D_VLD=1 next cycle, one transfer, IDLE after Busy falls.
REQ-029 ALU_OUT=0x1234 strobe -> transfers 0x34 then 0x12, TX_D_VLD=0 between them until Busy rises and falls.
REQ-030 Busy held 1 for 10 cycles, then RdData=0xA5 -> TX_D_VLD=1 and 0xA5 held stable until Busy=0, single transfer.
REQ-031 RdData=0x11 and ALU_OUT=0xABCD strobed in the same cycle -> with PEND_EN: 0x11, 0xCD, 0xAB and no Drop; without: 0x11 only and one Drop pulse.
REQ-032 Reset=1 for one cycle after byte 0x34 of ALU_OUT=0x1234 -> all outputs 0 next cycle, 0x12 never sent, IDLE.
